l_top_echo: RTL and testbench

L_TOP_ECHO -- requirements
Module: l_top

---
 rtl/l_top_echo_if.sv | 11 +
 rtl/l_top_echo.sv | 56 +++++
 tb/tb_l_top_echo.sv | 129 ++++++++++++
 3 files changed

// File: rtl/l_top_echo_if.sv
// Enqueue-style handshake bundle: strobe + message toward the receiver, ready back.
interface l_top_echo_if #(
    parameter int WIDTH = 128
);
    logic             enq__ENA;
    logic [WIDTH-1:0] enq_v;
    logic             enq__RDY;

    modport master (output enq__ENA, output enq_v, input enq__RDY);
    modport slave  (input enq__ENA, input enq_v, output enq__RDY);
endinterface

// File: rtl/l_top_echo.sv
// Echo block: queues request payloads and replays each one as an indication
// tagged with a fixed 16-bit length field in the low bits.
module l_top_echo #(
    parameter int          WIDTH      = 128,
    parameter int          DEPTH_LOG2 = 2,
    parameter logic [15:0] IND_LEN    = 16'd1
) (
    input logic           CLK,
    input logic           nRST,
    l_top_echo_if.slave   request,
    l_top_echo_if.master  indication
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = WIDTH - 16;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    logic [PW-1:0] mem_q [DEPTH];
    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic full, empty, do_enq, do_deq;

    // Ready is derived from state only, so a same-cycle dequeue never opens a slot.
    always_comb begin
        full     = (count_q == cnt_t'(DEPTH));
        empty    = (count_q == '0);
        do_enq   = request.enq__ENA & ~full;
        do_deq   = ~empty & indication.enq__RDY;
        wr_ptr_d = wr_ptr_q + ptr_t'(do_enq);
        rd_ptr_d = rd_ptr_q + ptr_t'(do_deq);
        count_d  = count_q + cnt_t'(do_enq) - cnt_t'(do_deq);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the empty gate on the output hides stale contents.
    always_ff @(posedge CLK) begin
        if (do_enq) mem_q[wr_ptr_q] <= request.enq_v[WIDTH-1:16];
    end

    assign request.enq__RDY     = ~full;
    assign indication.enq__ENA  = do_deq;
    assign indication.enq_v     = empty ? '0 : {mem_q[rd_ptr_q], IND_LEN};
endmodule

// File: tb/tb_l_top_echo.sv
// Randomized + directed bench for l_top_echo against a queue-based reference model.
module tb_l_top_echo;
    localparam int WIDTH = 128;
    localparam int PW    = WIDTH - 16;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [PW-1:0] model_q[$];

    always #5 CLK = ~CLK;

    l_top_echo_if #(.WIDTH(WIDTH)) request ();
    l_top_echo_if #(.WIDTH(WIDTH)) indication ();

    l_top_echo #(.WIDTH(WIDTH), .DEPTH_LOG2(2), .IND_LEN(16'd1)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .request    (request),
        .indication (indication)
    );

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Compare all outputs to the model, then advance the model across the next rising edge.
    task automatic cyc_now(input logic ena, input logic [PW-1:0] pay, input logic ind_rdy, input string tag);
        logic          exp_rdy, exp_ena, acc;
        logic [WIDTH-1:0] exp_v;
        request.enq__ENA    = ena;
        request.enq_v       = {pay, 16'hBEEF};
        indication.enq__RDY = ind_rdy;
        #1;
        exp_rdy = (model_q.size() < DEPTH);
        exp_ena = (model_q.size() > 0) && ind_rdy;
        exp_v   = (model_q.size() > 0) ? {model_q[0], 16'h0001} : '0;
        chk({tag, "_req_rdy"}, WIDTH'(request.enq__RDY), WIDTH'(exp_rdy));
        chk({tag, "_ind_ena"}, WIDTH'(indication.enq__ENA), WIDTH'(exp_ena));
        chk({tag, "_ind_v"}, indication.enq_v, exp_v);
        acc = ena && exp_rdy;
        @(posedge CLK);
        if (exp_ena) void'(model_q.pop_front());
        if (acc) model_q.push_back(pay);
    endtask

    task automatic cyc(input logic ena, input logic [PW-1:0] pay, input logic ind_rdy, input string tag);
        @(negedge CLK);
        cyc_now(ena, pay, ind_rdy, tag);
    endtask

    function automatic logic [PW-1:0] rnd_pay();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[PW-1:0];
    endfunction

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic pulse_reset(input logic [PW-1:0] first_pay);
        @(negedge CLK);
        nRST = 1'b0;
        indication.enq__RDY = 1'b1;
        request.enq__ENA = 1'b0;
        #1;
        model_q.delete();
        chk("rst_req_rdy", WIDTH'(request.enq__RDY), WIDTH'(1'b1));
        chk("rst_ind_ena", WIDTH'(indication.enq__ENA), '0);
        chk("rst_ind_v", indication.enq_v, '0);
        @(negedge CLK);
        nRST = 1'b1;
        cyc_now(1'b1, first_pay, 1'b0, "post_rst");
    endtask

    initial begin
        request.enq__ENA = 1'b0;
        request.enq_v = '0;
        indication.enq__RDY = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("reset_rdy", WIDTH'(request.enq__RDY), WIDTH'(1'b1));
        chk("reset_ena", WIDTH'(indication.enq__ENA), '0);
        chk("reset_v", indication.enq_v, '0);
        @(negedge CLK);
        nRST = 1'b1;

        // Single message, minimum latency
        cyc(1'b1, PW'(32'h00AB_CDEF), 1'b1, "single_in");
        cyc(1'b0, rnd_pay(), 1'b1, "single_out");
        cyc(1'b0, rnd_pay(), 1'b1, "single_idle");

        // Fill with host stalled, overflow attempt, then drain
        for (int i = 1; i <= 5; i++) cyc(1'b1, PW'(i), 1'b0, "fill");
        cyc(1'b1, PW'(99), 1'b1, "full_deq");
        cyc(1'b0, rnd_pay(), 1'b0, "after_full");
        for (int i = 0; i < 5; i++) cyc(1'b0, rnd_pay(), 1'b1, "drain");

        // Steady stream wrapping the pointers
        for (int i = 0; i < 12; i++) cyc(1'b1, PW'(100 + i), 1'b1, "stream");
        cyc(1'b0, rnd_pay(), 1'b1, "stream_end");

        // Reset with two messages queued
        cyc(1'b1, PW'(7), 1'b0, "preq");
        cyc(1'b1, PW'(8), 1'b0, "preq");
        pulse_reset(PW'(55));
        cyc(1'b0, rnd_pay(), 1'b1, "post_rst_out");
        cyc(1'b0, rnd_pay(), 1'b1, "post_rst_empty");

        // Empty FIFO with host ready toggling
        for (int i = 0; i < 4; i++) cyc(1'b0, rnd_pay(), 1'(i & 1), "empty_tog");

        // Random traffic
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 1)), rnd_pay(), ($urandom_range(0, 3) != 0), "rand");
        for (int i = 0; i < 6; i++) cyc(1'b0, rnd_pay(), 1'b1, "final_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
